// File: rtl/serial_tx_shift_if.sv
// Purpose: word handshake into the serial transmitter (valid/data_in from source, ready back).
// Latency: n/a, signal bundle only.
// Backpressure: source holds valid/data_in until it sees ready at a rising edge.
// Ports: valid (source->tx), data_in[WIDTH] (source->tx), ready (tx->source).
interface serial_tx_shift_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [WIDTH-1:0] data_in;
  logic             ready;

  modport master (output valid, output data_in, input ready);
  modport slave  (input valid, input data_in, output ready);
endinterface

// File: rtl/serial_tx_shift.sv
// Purpose: frame transmitter, sends start, WIDTH data bits, optional parity and stop on sdata.
// Latency: word accepted at edge N drives the start bit from edge N; frame is WIDTH+2+PARITY_EN cycles.
// Backpressure: ready only in IDLE and STOP; valid seen while ready=0 is dropped, not queued.
// Ports: clk, clear (async active-high reset), bus (valid/data_in/ready),
//        sdata (serial line, idles 1), busy (frame in progress), done (1-cycle pulse after STOP).
module serial_tx_shift #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clk,
  input  logic                clear,
  serial_tx_shift_if.slave    bus,
  output logic                sdata,
  output logic                busy,
  output logic                done
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par;
  logic             accept;
  logic             sdata_nxt;

  // ready depends on state only, so there is no path from valid back to ready.
  assign bus.ready = (state == IDLE) || (state == STOP);
  assign accept    = bus.valid && bus.ready;

  always_comb begin
    state_nxt = state;
    sdata_nxt = 1'b1;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (cnt == CW'(WIDTH - 1)) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
    // Outputs are registered from the next state, so the line changes exactly
    // at the edge that enters each slot.
    case (state_nxt)
      START:   sdata_nxt = 1'b0;
      DATA:    sdata_nxt = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      PARITY:  sdata_nxt = par;
      default: sdata_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      sdata <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      shreg <= '0;
      cnt   <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_nxt;
      sdata <= sdata_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == STOP);
      if (accept) begin
        shreg <= bus.data_in;
        par   <= (^bus.data_in) ^ PARITY_ODD;
      end else if (state_nxt == DATA) begin
        // The bit being launched this edge is dropped from the register.
        shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      end
      if (state_nxt == DATA) begin
        cnt <= (state == DATA) ? cnt + CW'(1) : '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_shift.sv
// Purpose: bench for serial_tx_shift over four parameter sets with a bit-level scoreboard.
// Latency: monitor checks every cycle at negedge; one expected entry per busy cycle.
// Backpressure: stimulus waits on ready with a bounded cycle budget.
module tb_serial_tx_shift;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  logic [3:0] sd, bz, dn, rdy;

  serial_tx_shift_if #(.WIDTH(8)) i0 ();
  serial_tx_shift_if #(.WIDTH(8)) i1 ();
  serial_tx_shift_if #(.WIDTH(8)) i2 ();
  serial_tx_shift_if #(.WIDTH(1)) i3 ();

  serial_tx_shift #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) d0 (
    .clk(clk), .clear(clear), .bus(i0), .sdata(sd[0]), .busy(bz[0]), .done(dn[0]));
  serial_tx_shift #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) d1 (
    .clk(clk), .clear(clear), .bus(i1), .sdata(sd[1]), .busy(bz[1]), .done(dn[1]));
  serial_tx_shift #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) d2 (
    .clk(clk), .clear(clear), .bus(i2), .sdata(sd[2]), .busy(bz[2]), .done(dn[2]));
  serial_tx_shift #(.WIDTH(1), .MSB_FIRST(1'b0), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) d3 (
    .clk(clk), .clear(clear), .bus(i3), .sdata(sd[3]), .busy(bz[3]), .done(dn[3]));

  assign rdy = {i3.ready, i2.ready, i1.ready, i0.ready};

  int W[4]    = '{8, 8, 8, 1};
  bit MSB[4]  = '{0, 1, 0, 0};
  bit PEN[4]  = '{1, 1, 0, 1};
  bit PODD[4] = '{0, 1, 0, 0};

  // Each entry: {last_bit_of_frame, expected sdata}.
  bit [1:0] expq [4][$];
  bit       exp_done [4];
  int       nvec = 0;
  int       nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Hand-computed frames are given as explicit bit lists; this only queues them.
  task automatic push_bits(input int d, input string bits);
    for (int i = 0; i < bits.len(); i++)
      expq[d].push_back({(i == bits.len() - 1) ? 1'b1 : 1'b0, (bits[i] == "1") ? 1'b1 : 1'b0});
  endtask

  // Monitor: one comparison of done and one of sdata per DUT per cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      bit [1:0] e;
      chk($sformatf("done%0d", d), dn[d], exp_done[d]);
      exp_done[d] = 1'b0;
      if (bz[d] === 1'b1) begin
        if (expq[d].size() == 0) begin
          chk($sformatf("unexpected_busy%0d", d), bz[d], 0);
        end else begin
          e = expq[d].pop_front();
          chk($sformatf("sdata%0d", d), sd[d], e[0]);
          exp_done[d] = e[1];
        end
      end else begin
        chk($sformatf("idle_line%0d", d), sd[d], 1);
      end
    end
  end

  task automatic drive(input int d, input bit v, input logic [31:0] w);
    case (d)
      0: begin i0.valid = v; i0.data_in = w[7:0]; end
      1: begin i1.valid = v; i1.data_in = w[7:0]; end
      2: begin i2.valid = v; i2.data_in = w[7:0]; end
      default: begin i3.valid = v; i3.data_in = w[0:0]; end
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input logic [31:0] w, input string bits, input bit hold);
    int n = 0;
    drive(d, 1'b1, w);
    while (rdy[d] !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(posedge clk);
    push_bits(d, bits);
    #1;
    if (!hold) drive(d, 1'b0, w);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size() + expq[3].size()) != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("drain_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    clear = 1'b1;
    for (int d = 0; d < 4; d++) begin
      drive(d, 1'b0, 0);
      exp_done[d] = 1'b0;
    end
    #3;
    chk("rst_sdata", sd, 4'hF);
    chk("rst_busy", bz, 4'h0);
    chk("rst_done", dn, 4'h0);
    chk("rst_ready", rdy, 4'hF);
    @(posedge clk); @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;

    // LSB-first even parity, 0xA5.
    send(0, 32'hA5, "01010010101", 1'b0);
    wait_idle();

    // MSB-first odd parity, 0x01.
    send(1, 32'h01, "00000000101", 1'b0);
    wait_idle();

    // No parity, back-to-back with valid held: FF then 00.
    send(2, 32'hFF, "0111111111", 1'b1);
    send(2, 32'h00, "0000000001", 1'b0);
    wait_idle();

    // Stray valid with other data in cycles 3 and 5 of a frame is ignored.
    send(0, 32'h3C, "00011110001", 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'hFF);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h00);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h81);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h00);
    wait_idle();

    // WIDTH=1: 4-cycle frame, ready comes back in STOP.
    send(3, 32'h1, "0111", 1'b0);
    chk("w1_ready_start", rdy[3], 0);
    @(posedge clk); #1;
    chk("w1_ready_data", rdy[3], 0);
    @(posedge clk); #1;
    chk("w1_ready_parity", rdy[3], 0);
    @(posedge clk); #1;
    chk("w1_ready_stop", rdy[3], 1);
    wait_idle();

    // Async clear mid-frame: line back to idle without a clock edge, no done, word lost.
    send(0, 32'h5A, "00101101001", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    #1;
    chk("clr_sdata", sd[0], 1);
    chk("clr_busy", bz[0], 0);
    chk("clr_ready", rdy[0], 1);
    chk("clr_done", dn[0], 0);
    expq[0].delete();
    exp_done[0] = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    // Recovery after the abort.
    send(0, 32'h80, "00000000111", 1'b0);
    wait_idle();

    for (int d = 0; d < 4; d++) chk($sformatf("queue_empty%0d", d), expq[d].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
